// File: rtl/rans_stream_decoder.sv
// rANS stream decoder: loads a STATE_WIDTH-bit state from a nibble stream,
// then repeatedly looks up a symbol from the live cumulative-frequency table,
// emits it, applies the rANS state update, and renormalises from the stream.
// Build option: ANS_DEC_PARALLEL_LOOKUP_EN selects a single-cycle parallel
// lookup; when undefined, the lookup scans the table one entry per cycle.
module rans_stream_decoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int SYM_COUNT   = 16,
  parameter int PROB_BITS   = 8,
  parameter int STATE_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 start,
  input  logic [15:0]                          num_syms,
  input  logic [SYM_COUNT*(PROB_BITS+1)-1:0]   counts_unpacked,
  input  logic [SYM_COUNT*(PROB_BITS+1)-1:0]   cumulative_unpacked,
  input  logic [SYM_WIDTH-1:0]                 in,
  input  logic                                 in_vld,
  output logic                                 in_rdy,
  output logic [SYM_WIDTH-1:0]                 out,
  output logic                                 out_vld,
  input  logic                                 out_rdy,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int CW   = PROB_BITS + 1;
  localparam int NIBS = STATE_WIDTH / SYM_WIDTH;
  localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int WW   = STATE_WIDTH + PROB_BITS + 1;
  localparam logic [STATE_WIDTH-1:0] L_MIN = STATE_WIDTH'(1) << (STATE_WIDTH - SYM_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOOKUP, S_EMIT, S_UPDATE, S_RENORM, S_FINISH
  } fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [15:0]            rem_q, rem_d;
  logic [NW-1:0]          nib_q, nib_d;
  logic [SYM_WIDTH-1:0]   sym_q, sym_d;
  logic                   err_q, err_d;

  logic [CW-1:0]          cnt_tbl [SYM_COUNT];
  logic [CW-1:0]          cum_tbl [SYM_COUNT];
  logic [PROB_BITS-1:0]   slot;
  logic [STATE_WIDTH-1:0] shifted;
  logic [WW-1:0]          upd_w;
  logic                   hit;
  logic                   last;
  logic [SYM_WIDTH-1:0]   hit_sym;

  // Slice the flat table buses into per-symbol entries.
  always_comb begin
    for (int s = 0; s < SYM_COUNT; s++) begin
      cnt_tbl[s] = counts_unpacked[s*CW +: CW];
      cum_tbl[s] = cumulative_unpacked[s*CW +: CW];
    end
  end

  assign slot    = state_q[PROB_BITS-1:0];
  assign shifted = {state_q[STATE_WIDTH-SYM_WIDTH-1:0], in};

`ifdef ANS_DEC_PARALLEL_LOOKUP_EN
  // Parallel compare of every cum_hi against the slot; lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    last    = 1'b1;
    for (int s = SYM_COUNT - 1; s >= 0; s--) begin
      if ({1'b0, slot} < cum_tbl[s]) begin
        hit     = 1'b1;
        hit_sym = SYM_WIDTH'(s);
      end
    end
  end
`else
  localparam int IW = (SYM_COUNT > 1) ? $clog2(SYM_COUNT) : 1;
  logic [IW-1:0] idx_q, idx_d;

  // Sequential scan: one table entry per LOOKUP cycle, index rests at zero elsewhere.
  always_comb begin
    hit     = ({1'b0, slot} < cum_tbl[idx_q]);
    hit_sym = SYM_WIDTH'(idx_q);
    last    = (idx_q == IW'(SYM_COUNT - 1));
    if (!en)                    idx_d = idx_q;
    else if (fsm_q == S_LOOKUP) idx_d = idx_q + 1'b1;
    else                        idx_d = '0;
  end

  // Scan index register.
  always_ff @(posedge clk) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end
`endif

  // Next-state and datapath: everything holds unless en is high.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rem_d   = rem_q;
    nib_d   = nib_q;
    sym_d   = sym_q;
    err_d   = err_q;
    // rANS update in a widened domain; the final truncation drops any wrap.
    upd_w   = WW'(cnt_tbl[sym_q]) * WW'(state_q >> PROB_BITS) + WW'(slot)
              - (WW'(cum_tbl[sym_q]) - WW'(cnt_tbl[sym_q]));
    if (en) begin
      case (fsm_q)
        S_IDLE: begin
          if (start) begin
            rem_d = num_syms;
            err_d = 1'b0;
            if (num_syms == 16'd0) begin
              fsm_d = S_FINISH;
            end else begin
              state_d = '0;
              nib_d   = '0;
              fsm_d   = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_vld) begin
            state_d = shifted;
            nib_d   = nib_q + 1'b1;
            if (nib_q == NW'(NIBS - 1)) fsm_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            sym_d = hit_sym;
            fsm_d = S_EMIT;
          end else if (last) begin
            err_d = 1'b1;
            fsm_d = S_FINISH;
          end
        end
        S_EMIT: begin
          if (out_rdy) fsm_d = S_UPDATE;
        end
        S_UPDATE: begin
          state_d = upd_w[STATE_WIDTH-1:0];
          rem_d   = rem_q - 16'd1;
          fsm_d   = (rem_q == 16'd1) ? S_FINISH : S_RENORM;
        end
        S_RENORM: begin
          if (state_q >= L_MIN)  fsm_d   = S_LOOKUP;
          else if (in_vld)       state_d = shifted;
        end
        S_FINISH: fsm_d = S_IDLE;
        default:  fsm_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      rem_q   <= '0;
      nib_q   <= '0;
      sym_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      nib_q   <= nib_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
    end
  end

  assign in_rdy  = (fsm_q == S_LOAD) || ((fsm_q == S_RENORM) && (state_q < L_MIN));
  assign out_vld = (fsm_q == S_EMIT);
  assign out     = sym_q;
  assign busy    = (fsm_q != S_IDLE);
  assign done    = (fsm_q == S_FINISH);
  assign err     = err_q;

endmodule
